alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 202 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, optional iterative mul/div.
// Ports: i_clk, i_rst (async high), i_valid/o_ready in, o_valid/i_ready out,
// i_operand_a/b, i_alu_op[3:0], o_alu_data. Macro: ALU_MULTICYCLE_MULDIV_EN.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic [3:0]       i_alu_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] simple_res;

  assign o_ready = (state_q == IDLE) ||
                   ((state_q == DONE) && i_ready);
  assign o_valid = (state_q == DONE);
  assign accept  = i_valid && o_ready;
  assign sh      = i_operand_b[SHW-1:0];

  always_comb begin
    simple_res = i_operand_b;
    case (i_alu_op)
      4'h0: simple_res = i_operand_a + i_operand_b;
      4'h1: simple_res = i_operand_a - i_operand_b;
      4'h2: simple_res = {{(WIDTH-1){1'b0}},
                          $signed(i_operand_a) < $signed(i_operand_b)};
      4'h3: simple_res = {{(WIDTH-1){1'b0}}, i_operand_a < i_operand_b};
      4'h4: simple_res = i_operand_a ^ i_operand_b;
      4'h5: simple_res = i_operand_a | i_operand_b;
      4'h6: simple_res = i_operand_a & i_operand_b;
      4'h7: simple_res = i_operand_a << sh;
      4'h8: simple_res = i_operand_a >> sh;
      4'h9: simple_res = $signed(i_operand_a) >>> sh;
      default: simple_res = i_operand_b;
    endcase
  end

`ifdef ALU_MULTICYCLE_MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q, dv_q;
  logic [CW-1:0]    cnt_q;

  logic             is_md, last, sgn_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n, md_res;

  assign is_md  = i_alu_op[3] & (i_alu_op[2] | i_alu_op[1]);
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign sgn_in = ~i_alu_op[0];
  assign a_mag  = (sgn_in & i_operand_a[WIDTH-1]) ? -i_operand_a
                                                  : i_operand_a;
  assign b_mag  = (sgn_in & i_operand_b[WIDTH-1]) ? -i_operand_b
                                                  : i_operand_b;

  // One iteration: op_q[2] selects restoring divide, else shift-add mul.
  // Mul: {hi,lo} is the product/multiplier pair shifted right each step.
  // Div: hi is the partial remainder, lo shifts dividend out, quotient in.
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, dv_q};
    shl  = {hi_q, lo_q[WIDTH-1]};
    ge   = (shl >= {1'b0, dv_q});
    hi_n = hi_q;
    lo_n = lo_q;
    if (op_q[2]) begin
      hi_n = ge ? (shl[WIDTH-1:0] - dv_q) : shl[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else if (lo_q[0]) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = {1'b0, hi_q[WIDTH-1:1]};
      lo_n = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    md_res = lo_n;
    if (!op_q[2]) begin
      md_res = op_q[0] ? hi_n : lo_n;
    end else if (b_q == '0) begin
      md_res = op_q[1] ? a_q : '1;
    end else if (op_q[1]) begin
      md_res = (~op_q[0] & a_q[WIDTH-1]) ? -hi_n : hi_n;
    end else begin
      md_res = (~op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
               ? -lo_n : lo_n;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dv_q  <= '0;
      cnt_q <= '0;
    end else if (accept && is_md) begin
      op_q  <= i_alu_op[2:0];
      a_q   <= i_operand_a;
      b_q   <= i_operand_b;
      hi_q  <= '0;
      cnt_q <= '0;
      if (i_alu_op[2]) begin
        lo_q <= a_mag;
        dv_q <= b_mag;
      end else begin
        lo_q <= i_operand_b;
        dv_q <= i_operand_a;
      end
    end else if (state_q == BUSY) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
          state_d = is_md ? BUSY : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (accept) begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
          state_d = is_md ? BUSY : DONE;
`else
          state_d = DONE;
`endif
        end else if (i_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
        if (last) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_alu_data <= '0;
`ifdef ALU_MULTICYCLE_MULDIV_EN
    end else if (accept && !is_md) begin
      o_alu_data <= simple_res;
    end else if ((state_q == BUSY) && last) begin
      o_alu_data <= md_res;
    end
`else
    end else if (accept) begin
      o_alu_data <= simple_res;
    end
`endif
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases,
// randomized ops against a behavioural model, stall and reset scenarios.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] opa, opb;
  logic [3:0]   op;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_operand_a (opa),
    .i_operand_b (opb),
    .i_alu_op    (op),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_alu_data  (o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
`ifdef ALU_MULTICYCLE_MULDIV_EN
    return o >= 4'd10;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural reference computed from the op definitions.
  function automatic logic [31:0] model(input logic [3:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    logic [63:0] a64, b64, p;
    logic [4:0] s;
    sa = a; sb = b; a64 = {32'd0, a}; b64 = {32'd0, b};
    p = a64 * b64;
    s = b[4:0];
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return (sa < sb) ? 32'd1 : 32'd0;
      4'd3: return (a < b) ? 32'd1 : 32'd0;
      4'd4: return a ^ b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a << s;
      4'd8: return a >> s;
      4'd9: return sa >>> s;
`ifdef ALU_MULTICYCLE_MULDIV_EN
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return sa % sb;
      end
      4'd15: return (b == 0) ? a : a % b;
`endif
      default: return b;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    chk({tag, "_rdy"}, o_ready, 1'b1);
    i_valid = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    i_valid = 1'b0;
    op = 4'($urandom); opa = $urandom; opb = $urandom;
  endtask

  task automatic wait_result(input int exp_lat, input logic [31:0] exp,
                             input string tag);
    int lat;
    bit busy_ok;
    lat = 1; busy_ok = 1'b1;
    while (!o_valid && lat < 200) begin
      if (o_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy_rdy"}, busy_ok, 1'b1);
    chk({tag, "_data"}, o_data, exp);
    chk({tag, "_done_rdy"}, o_ready, 1'b0);
  endtask

  task automatic retire(input string tag);
    i_ready = 1'b1;
    #1;
    chk({tag, "_ret_rdy"}, o_ready, 1'b1);
    @(negedge clk);
    chk({tag, "_idle_vld"}, o_valid, 1'b0);
    chk({tag, "_idle_rdy"}, o_ready, 1'b1);
    i_ready = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string tag);
    issue(o, a, b, tag);
    wait_result(is_long(o) ? W + 1 : 1, exp, tag);
    retire(tag);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb, held;
    bit saw;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    op = '0; opa = '0; opb = '0;
    #1;
    chk("rst_vld", o_valid, 1'b0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_rdy", o_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
    do_op(4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, "sra");
    do_op(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    do_op(4'd7, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, "sll");
`ifdef ALU_MULTICYCLE_MULDIV_EN
    do_op(4'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "mul");
    do_op(4'd11, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu");
    do_op(4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    do_op(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    do_op(4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu0");
    do_op(4'd14, 32'd7, 32'd0, 32'd7, "rem0");
    do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf");
    do_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "removf");
`else
    do_op(4'd10, 32'd5, 32'd9, 32'd9, "op10");
    do_op(4'd15, 32'h1234, 32'hABCD_0001, 32'hABCD_0001, "op15");
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))
                                         : 32'($urandom);
      do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i));
    end

    // Result held under back-pressure; pending request waits for i_ready.
    ro = 4'hE; ra = 32'hFFFF_FF00 + 32'($urandom_range(0, 200));
    rb = 32'($urandom_range(3, 30));
    held = model(ro, ra, rb);
    issue(ro, ra, rb, "stall");
    wait_result(is_long(ro) ? W + 1 : 1, held, "stall");
    i_valid = 1'b1; op = 4'd0; opa = 32'd3; opb = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_vld%0d", k), o_valid, 1'b1);
      chk($sformatf("stall_data%0d", k), o_data, held);
      chk($sformatf("stall_rdy%0d", k), o_ready, 1'b0);
    end
    i_ready = 1'b1;
    #1;
    chk("b2b_rdy", o_ready, 1'b1);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0;
    chk("b2b_vld", o_valid, 1'b1);
    chk("b2b_data", o_data, 32'd7);
    retire("b2b");

    // Asynchronous reset in the middle of an operation.
`ifdef ALU_MULTICYCLE_MULDIV_EN
    issue(4'd13, 32'd100, 32'd7, "rstop");
    repeat (9) @(negedge clk);
`else
    issue(4'd0, 32'h11, 32'h22, "rstop");
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", o_valid, 1'b0);
    chk("mid_rst_data", o_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(4'd0, 32'd1, 32'd1, 32'd2, "post_rst_add");
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) saw = 1'b1;
    end
    chk("no_stale_vld", saw, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
